// File: rtl/mips_pkg.sv
// mips_pkg: shared instruction field positions, widths and fetch buffer entry type.
package mips_pkg;
    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int IMM10_HI = 9;
    localparam int IMM10_LO = 0;
    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int IMM10_W  = 10;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: 2-entry {pc, instr} buffer; entry 0 is always the head register.
module fetch_skid_fifo
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic [1:0]   count_o,
    output logic         empty_o,
    output logic         full_o
);
    fetch_entry_t ent_q [2];
    fetch_entry_t ent_d [2];
    logic [1:0] cnt_q, cnt_d, base;
    logic pop_en;

    always_comb begin
        ent_d  = ent_q;
        pop_en = pop_i && cnt_q != 2'd0;
        base   = cnt_q - {1'b0, pop_en};
        if (pop_en) ent_d[0] = ent_q[1];
        if (push_i && base != 2'd2) ent_d[base[0]] = push_data_i;
        cnt_d  = flush_i ? 2'd0 : base + {1'b0, push_i && base != 2'd2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{default: '0};
            cnt_q <= 2'd0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    // The credit rule upstream must make a push into a full, non-popping buffer impossible.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push_i && !flush_i && base == 2'd2)) else $error("fetch_skid_fifo overflow");
    end

    assign head_o  = ent_q[0];
    assign count_o = cnt_q;
    assign empty_o = cnt_q == 2'd0;
    assign full_o  = cnt_q == 2'd2;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, credit-limited imem requests, stale-response dropping and
// a 2-entry decoded-output buffer.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [31:0]        imem_addr,
    input  logic               imem_rsp_valid,
    input  logic [31:0]        imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_instr,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rs,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
    output logic [IMM10_W-1:0] out_imm10
);
    logic [31:0] pc_q, pc_d;
    logic [1:0]  outst_q, outst_d, drop_q, drop_d, fifo_cnt, aq_idx;
    logic [31:0] aq_q [2];
    logic [31:0] aq_d [2];
    logic        req_fire, rsp_from_aq, fifo_empty, fifo_full;
    fetch_entry_t head, push_ent;

    assign imem_req_valid = rst_n && !redirect_valid &&
                            ({1'b0, outst_q} + {1'b0, fifo_cnt} < 3'(MAX_OUTSTANDING));
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // With nothing in flight, a response can only answer the request fired this same cycle.
    assign rsp_from_aq    = imem_rsp_valid && outst_q != 2'd0;
    assign aq_idx         = outst_q - {1'b0, rsp_from_aq};
    assign push_ent       = '{pc: rsp_from_aq ? aq_q[0] : pc_q, instr: imem_rsp_data};

    always_comb begin
        aq_d = aq_q;
        if (rsp_from_aq) aq_d[0] = aq_q[1];
        if (req_fire && !(imem_rsp_valid && outst_q == 2'd0)) aq_d[aq_idx[0]] = pc_q;
        pc_d    = redirect_valid ? redirect_pc : (req_fire ? pc_q + 32'd4 : pc_q);
        outst_d = outst_q + {1'b0, req_fire} - {1'b0, imem_rsp_valid};
        drop_d  = redirect_valid ? outst_q - {1'b0, imem_rsp_valid}
                                 : drop_q - {1'b0, imem_rsp_valid && drop_q != 2'd0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            outst_q <= 2'd0;
            drop_q  <= 2'd0;
            aq_q    <= '{default: '0};
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            aq_q    <= aq_d;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (imem_rsp_valid && drop_q == 2'd0 && !redirect_valid),
        .push_data_i (push_ent),
        .pop_i       (out_valid && out_ready && !redirect_valid),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (fifo_cnt),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    assign out_valid  = !fifo_empty;
    assign out_pc     = head.pc;
    assign out_instr  = head.instr;
    assign out_opcode = head.instr[OPC_HI:OPC_LO];
    assign out_rs     = head.instr[RS_HI:RS_LO];
    assign out_rt     = head.instr[RT_HI:RT_LO];
    assign out_rd     = head.instr[RD_HI:RD_LO];
    assign out_imm10  = head.instr[IMM10_HI:IMM10_LO];

    logic unused;
    assign unused = fifo_full;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a 0- or 3-cycle memory model.
module tb_instr_fetch;
    logic        clk = 0, rst_n;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_addr, imem_rsp_data;
    logic        redirect_valid, out_valid, out_ready;
    logic [31:0] redirect_pc, out_pc, out_instr;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [9:0]  out_imm10;
    logic        slow;
    logic [2:0]  sv;
    logic [31:0] sa [3];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_imm10(out_imm10)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a == 32'hC ? 32'h8C22_03FF : (32'h1000_0000 | a);
    endfunction

    // Memory: combinational response when !slow, else a 3-cycle pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sv <= 3'b0;
        else begin
            sv    <= {sv[1:0], slow && imem_req_valid && imem_req_ready};
            sa[0] <= imem_addr;
            sa[1] <= sa[0];
            sa[2] <= sa[1];
        end
    end
    assign imem_rsp_valid = slow ? sv[2] : imem_req_valid && imem_req_ready;
    assign imem_rsp_data  = word(slow ? sa[2] : imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic stable, got;
        rst_n = 0; imem_req_ready = 1; out_ready = 1; redirect_valid = 0; redirect_pc = 0; slow = 0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        rst_n = 1;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_addr", imem_addr, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("stream_addr", imem_addr, 32'(4 * i));
            check("stream_valid", out_valid, 1);
            check("stream_pc", out_pc, 32'(4 * (i - 1)));
            check("stream_instr", out_instr, word(32'(4 * (i - 1))));
        end
        check("dec_opcode", out_opcode, 6'h23);
        check("dec_rs", out_rs, 5'd1);
        check("dec_rt", out_rt, 5'd2);
        check("dec_rd", out_rd, 5'd0);
        check("dec_imm10", out_imm10, 10'h3FF);

        // backpressure
        rst_n = 0; out_ready = 0;
        @(negedge clk);
        rst_n = 1; n = 0; stable = 1;
        repeat (10) begin
            #1;
            if (imem_req_valid && imem_req_ready) n++;
            if (out_valid && out_pc !== 0) stable = 0;
            @(negedge clk);
        end
        check("bp_req_count", n, 2);
        check("bp_req_valid", imem_req_valid, 0);
        check("bp_stable", stable, 1);
        check("bp_head_pc", out_pc, 0);
        out_ready = 1;
        @(negedge clk);
        check("bp_drain_pc4", out_pc, 4);
        check("bp_resume_addr", imem_addr, 8);
        check("bp_resume_valid", imem_req_valid, 1);
        @(negedge clk);
        check("bp_drain_pc8", out_pc, 8);

        // redirect with two outstanding, 3-cycle memory
        rst_n = 0; slow = 1;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        check("rd2_credit_stall", imem_req_valid, 0);
        redirect_valid = 1; redirect_pc = 32'h100;
        @(negedge clk);
        check("rd2_drop_cnt", dut.drop_q, 2);
        check("rd2_addr", imem_addr, 32'h100);
        check("rd2_out_valid", out_valid, 0);
        redirect_valid = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("rd2_got", got, 1);
        check("rd2_out_pc", out_pc, 32'h100);
        check("rd2_out_instr", out_instr, word(32'h100));

        // redirect coincident with a response and a pop
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        check("rdc_pre_valid", out_valid, 1);
        check("rdc_pre_rsp", imem_rsp_valid, 1);
        check("rdc_pre_outst", dut.outst_q, 1);
        redirect_valid = 1; redirect_pc = 32'h200;
        @(negedge clk);
        check("rdc_empty", out_valid, 0);
        check("rdc_drop_cnt", dut.drop_q, 0);
        check("rdc_addr", imem_addr, 32'h200);
        redirect_valid = 0;
        #1;
        check("rdc_req_valid", imem_req_valid, 1);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("rdc_got", got, 1);
        check("rdc_out_pc", out_pc, 32'h200);

        // request stall
        rst_n = 0; slow = 0; imem_req_ready = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (5) begin
            #1;
            check("stall_addr", imem_addr, 0);
            @(negedge clk);
        end
        check("stall_out_valid", out_valid, 0);
        imem_req_ready = 1;
        @(negedge clk);
        check("stall_next_addr", imem_addr, 4);
        check("stall_out_pc0", out_pc, 0);
        @(negedge clk);
        check("stall_out_pc4", out_pc, 4);

        // asynchronous mid-stream reset
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_req_valid", imem_req_valid, 0);
        check("async_out_pc", out_pc, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("restart_addr", imem_addr, 0);
        check("restart_req_valid", imem_req_valid, 1);
        @(negedge clk);
        check("restart_out_pc", out_pc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the MIPS core. It owns the program counter and issues in-order word fetches to instruction memory over a valid/ready request channel with an unstalled response channel. Returned words are buffered and presented to decode with their instruction fields already split out. `out_imm10` is the 10-bit immediate that feeds `sign_extender` directly.

## Interface

**Parameters**
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `MAX_OUTSTANDING`, default `2`: the credit limit. It is fixed at 2, equal to the buffer depth.

**Ports** (name, direction, width, meaning)
- `clk` in 1: the single clock. Everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_addr` out 32: fetch byte address (the current PC).
- `imem_rsp_valid` in 1: response word valid. It cannot be stalled, and responses return in request order.
- `imem_rsp_data` in 32: instruction word.
- `redirect_valid` in 1: branch or jump redirect from execute.
- `redirect_pc` in 32: new PC.
- `out_valid` out 1: decoded instruction available.
- `out_ready` in 1: decode accepts.
- `out_pc` out 32: PC of the presented instruction.
- `out_instr` out 32: raw instruction word.
- `out_opcode` out 6: `instr[31:26]`.
- `out_rs` out 5: `instr[25:21]`.
- `out_rt` out 5: `instr[20:16]`.
- `out_rd` out 5: `instr[15:11]`.
- `out_imm10` out 10: `instr[9:0]`.

## Operation

**State**
- `pc`.
- `outstanding`: requests accepted but not yet answered, 0..2.
- `drop_cnt`: responses still to be discarded, 0..2.
- A 2-entry FIFO of {pc, instr}.

**Issue**
- `imem_req_valid` = `!redirect_valid && (outstanding + fifo_count < 2)`.
- On a request handshake: `pc <= pc + 4` and `outstanding` increments.
- `imem_addr` = `pc`.

**Responses**
- Each response decrements `outstanding`.
- If `drop_cnt > 0`, the response is discarded and `drop_cnt` decrements.
- Otherwise {pc of that request, data} is pushed into the FIFO. The request PCs are tracked in a 2-deep address queue alongside `outstanding`.
- The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure.

**Output**
- `out_valid` = FIFO not empty.
- All `out_*` fields come from the FIFO head register.
- The head pops on `out_valid && out_ready`.

**Redirect** (highest priority)
- `pc <= redirect_pc`, and the FIFO is cleared.
- `drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0)`.
- No request is issued in the redirect cycle.
- A pop or push in the same cycle is void.
- Fetch resumes from `redirect_pc` on the next cycle, subject to credit.

**Simultaneous push and pop** in one cycle are both performed, so the count is unchanged.

**Reset**
- Asserting `rst_n` low at any time, including mid-fetch, clears everything immediately and asynchronously:
  - `pc = RESET_PC`
  - `outstanding = 0`
  - `drop_cnt = 0`
  - FIFO empty
  - `out_valid = 0`, `imem_req_valid = 0`
  - all `out_*` data = 0
- Responses arriving after reset release, for requests issued before reset, are outside the contract. The memory is reset together with this block.

## Timing
- **First request:** `imem_req_valid` rises in the first cycle after `rst_n` deasserts, with `imem_addr = RESET_PC`.
- **Latency:** a response in cycle N gives `out_valid` in cycle N+1 (one register).
- **Best-case throughput:** one instruction per cycle, with single-cycle memory and `out_ready` held at 1.
- **Credit stall:** when the FIFO is full and `out_ready = 0`, requests stop.
- **Redirect penalty:** the first fetch from the new PC occurs in cycle R+1, and `out_valid` is 0 in cycle R+1 at minimum.
- **Stability:** `out_*` holds stable while `out_valid && !out_ready`.

## Structure
- **Shared package `mips_pkg`:**
  - instruction field positions (`OPC_HI/LO`, `RS_HI/LO`, `RT_HI/LO`, `RD_HI/LO`, `IMM10_HI/LO`)
  - widths `OPC_W=6`, `REG_W=5`, `IMM10_W=10`
  - the default reset PC constant
- **Sub-module `fetch_skid_fifo`:** 2-entry {pc, instr} FIFO with push, pop and flush, and count, empty and full flags.
- **Top-level logic:** the PC, credit counter and drop counter stay in `instr_fetch`.

## Test plan
- **Reset and steady stream.** Release reset with `RESET_PC=0`, 1-cycle memory, `out_ready=1`.
  - Required: addresses 0, 4, 8, 12 on consecutive cycles.
  - Required: `out_pc` 0, 4, 8, 12 on consecutive cycles with no bubbles.
  - Required: word `32'h8C22_03FF` decodes to opcode `6'h23`, rs 1, rt 2, rd 0, imm10 `10'h3FF`.
- **Backpressure.** Hold `out_ready=0` for 10 cycles.
  - Required: exactly 2 requests issued, then `imem_req_valid=0`.
  - Required: `out_pc=0` held stable throughout.
  - Required: on release, 0 and 4 drain in order and fetching resumes at 8.
- **Redirect with 2 outstanding.** Use 3-cycle memory and assert a redirect to `0x100`.
  - Required: both stale responses are dropped.
  - Required: the next `out_pc` is `0x100`.
  - Required: no instruction from before the redirect reaches the output.
- **Redirect coincident with response and pop.**
  - Required: the FIFO empties.
  - Required: `drop_cnt` equals `outstanding - 1`.
  - Required: the next address is `redirect_pc`.
- **Request stall.** Hold `imem_req_ready=0` for 5 cycles.
  - Required: `imem_addr` stays constant.
  - Required: `pc` does not advance.
  - Required: the address is issued exactly once after ready.
- **Mid-stream reset.** Pull `rst_n` low asynchronously between clock edges.
  - Required: `out_valid` and `imem_req_valid` fall immediately.
  - Required: after release, fetching restarts at `RESET_PC`.
